// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit FIFO and start/done feeder for the UART transmitter
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   wr_en, wr_data    host write strobe and byte
//   full, empty       FIFO status (combinational from registered count)
//   level             current entry count, 0..2^ADDR_W
//   overflow          sticky flag, set when a write is dropped on full
//   tx_start          one-cycle start pulse to the transmitter
//   tx_dout           byte for the transmitter, held until the next pop
//   tx_done_tick      one-cycle completion pulse from the transmitter

module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_dout,
  input  logic              tx_done_tick
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  state_t state;
  state_t state_next;

  logic wr_accept;
  logic pop;

  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign level     = count;
  assign wr_accept = wr_en & ~full;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a done tick arriving while idle is ignored
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (!empty)      state_next = S_WAIT;
      S_WAIT: if (tx_done_tick) state_next = S_IDLE;
      default:                 state_next = S_IDLE;
    endcase
  end

  // Output decode: the only pop source is the idle state seeing queued data
  always_comb begin
    pop = 1'b0;
    if (state == S_IDLE && !empty) begin
      pop = 1'b1;
    end
  end

  // Storage array; no reset needed, stale entries are never read
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, count and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      // A write against a full FIFO is lost even if a pop frees a slot this cycle
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Registered transmitter handshake: tx_start is high in the first WAIT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_dout  <= '0;
    end else begin
      tx_start <= pop;
      if (pop) begin
        tx_dout <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_dout;
  logic       tx_done_tick;

  int n_checks;
  int n_fail;
  int cyc;

  // Transmitter model state
  int       frame_len;
  int       busy;
  int       proto_err;
  logic [7:0] rx_q[$];
  int       start_q[$];
  int       done_q[$];

  uart_tx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .tx_start     (tx_start),
    .tx_dout      (tx_dout),
    .tx_done_tick (tx_done_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // Model transmitter: captures the byte on tx_start, returns a one-cycle
  // done tick frame_len cycles later, and flags a start while still busy.
  always @(negedge clk) begin
    if (reset) begin
      busy = 0;
      tx_done_tick = 1'b0;
    end else begin
      tx_done_tick = 1'b0;
      if (busy > 0) begin
        busy = busy - 1;
        if (busy == 0) begin
          tx_done_tick = 1'b1;
          done_q.push_back(cyc);
        end
      end
      if (tx_start) begin
        if (busy != 0) proto_err = proto_err + 1;
        busy = frame_len;
        rx_q.push_back(tx_dout);
        start_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    start_q.delete();
    done_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int c = 0; c < budget && rx_q.size() < n; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int maxlvl;
    int idx;
    n_checks = 0; n_fail = 0; cyc = 0; busy = 0; proto_err = 0;
    frame_len = 160;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done_tick = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Reset values and quiet idle
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_dout", tx_dout, 0);
    check("rst_overflow", overflow, 0);
    repeat (100) @(negedge clk);
    check("idle_no_start", rx_q.size(), 0);

    // Single byte: level=1 after write edge, tx_start one edge later
    frame_len = 160;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk); wr_en = 1'b0;
    check("single_level1", level, 1);
    check("single_not_empty", empty, 0);
    check("single_start_early", tx_start, 0);
    @(negedge clk);
    check("single_start", tx_start, 1);
    check("single_dout", tx_dout, 8'hA5);
    check("single_level0", level, 0);
    @(negedge clk);
    check("single_start_1cyc", tx_start, 0);
    repeat (170) @(negedge clk);
    check("single_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("single_byte", rx_q[0], 8'hA5);
    check("single_empty_after", empty, 1);

    // Burst to full while in WAIT, then overflow on the 17th write
    do_reset();
    frame_len = 40;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk); wr_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(negedge clk);
    end
    check("burst_full", full, 1);
    check("burst_level16", level, 16);
    check("burst_no_ovf_yet", overflow, 0);
    wr_data = 8'hFF;
    @(negedge clk); wr_en = 1'b0;
    check("burst_overflow", overflow, 1);
    check("burst_level_kept", level, 16);
    wait_rx(17, 2000);
    repeat (45) @(negedge clk);
    check("burst_count", rx_q.size(), 17);
    if (rx_q.size() == 17) begin
      check("burst_first", rx_q[0], 8'hEE);
      for (int i = 1; i <= 16; i++) check($sformatf("burst_byte%0d", i), rx_q[i], 32'(i));
    end
    if (start_q.size() == 17 && done_q.size() >= 16) begin
      for (int i = 1; i <= 16; i++)
        check($sformatf("burst_gap%0d", i), start_q[i] - done_q[i-1], 2);
    end
    check("burst_empty", empty, 1);
    check("burst_ovf_sticky", overflow, 1);

    // Simultaneous write and pop with level 3
    do_reset();
    check("ovf_cleared", overflow, 0);
    frame_len = 40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
    end
    @(negedge clk); wr_en = 1'b0;
    check("simul_level_pre", level, 3);
    begin
      int c;
      for (c = 0; c < 200 && !tx_done_tick; c++) @(posedge clk);
      check("simul_done_seen", 32'(c < 200), 1);
    end
    @(negedge clk);
    check("simul_level_before", level, 3);
    wr_en = 1'b1; wr_data = 8'h34;
    @(negedge clk); wr_en = 1'b0;
    check("simul_level_kept", level, 3);
    check("simul_start", tx_start, 1);
    check("simul_dout", tx_dout, 8'h31);
    wait_rx(5, 1000);
    check("simul_count", rx_q.size(), 5);
    if (rx_q.size() == 5)
      for (int i = 0; i < 5; i++) check($sformatf("simul_byte%0d", i), rx_q[i], 32'h30 + 32'(i));

    // Pointer wrap: 40 bytes with level throttled to at most 8
    do_reset();
    frame_len = 4;
    maxlvl = 0; idx = 0;
    for (int c = 0; c < 3000 && idx < 40; c++) begin
      @(negedge clk);
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (level < 8) begin
        wr_en = 1'b1; wr_data = 8'h40 + 8'(idx); idx = idx + 1;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk); wr_en = 1'b0;
    check("wrap_all_written", idx, 40);
    wait_rx(40, 1000);
    check("wrap_count", rx_q.size(), 40);
    if (rx_q.size() == 40)
      for (int i = 0; i < 40; i++) check($sformatf("wrap_byte%0d", i), rx_q[i], 32'h40 + 32'(i));
    check("wrap_max_level_ok", 32'(maxlvl <= 8), 1);
    check("wrap_no_overflow", overflow, 0);

    // Reset in WAIT with 5 bytes queued
    do_reset();
    frame_len = 160;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
    end
    @(negedge clk); wr_en = 1'b0;
    check("mid_level5", level, 5);
    repeat (3) @(negedge clk);
    check("mid_sent_one", rx_q.size(), 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("mid_level0", level, 0);
    check("mid_empty", empty, 1);
    check("mid_start0", tx_start, 0);
    check("mid_dout0", tx_dout, 0);
    repeat (200) @(negedge clk);
    check("mid_nothing_sent", rx_q.size(), 1);
    check("proto_no_overlap", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
